writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Pipeline stage 5 (writeback): consumes IR/ADDR/DATA from the memory stage and commits ALU/LW results to the register file.
//  - Owns the 16-entry general register file: two combinational read ports with write bypass.
//  - Owns a per-register busy scoreboard used by decode for hazard detection.
//  - Maintains a retired-instruction counter.
// PARAMETERS
//  DW    16  data/instruction width
//  NREG  16  number of registers; index = IR[11:8] (rd), 4 bits
//  CNTW  16  width of retired-instruction counter
// PORTS
//  CLK        in   1     clock; all state updates on posedge
//  RST        in   1     asynchronous reset, active-high
//  STAGE5IN   in   1     memory-stage output valid this cycle
//  IRIN       in   DW    instruction; op = IRIN[15:12] (`GET_OP), rd = IRIN[11:8]
//  ADDRIN     in   DW    address from memory stage (unused for commit; logged to WB_ADDR)
//  DATAIN     in   DW    result (ALU result or LW load data)
//  RADDR_A    in   4     read port A index
//  RADDR_B    in   4     read port B index
//  RDATA_A    out  DW    read data A (combinational)
//  RDATA_B    out  DW    read data B (combinational)
//  ISSUE_EN   in   1     decode issuing a register-writing instruction this cycle
//  ISSUE_RD   in   4     destination of that instruction
//  HAZARD_A   out  1     RADDR_A busy and not bypassed this cycle
//  HAZARD_B   out  1     RADDR_B busy and not bypassed this cycle
//  WB_EN      out  1     registered: a register write committed on last posedge
//  WB_RD      out  4     registered: register written
//  WB_DATA    out  DW    registered: value written
//  WB_ADDR    out  DW    registered: ADDRIN of last valid instruction
//  STAGE5OUT  out  1     registered: one-cycle pulse per retired instruction
//  RETIRED    out  CNTW  retired-instruction count
// BEHAVIOUR
//  Reset (async, RST=1): all 16 registers = 0; busy[15:0] = 0.
//   WB_EN = 0, WB_RD = 0, WB_DATA = 0, WB_ADDR = 0, STAGE5OUT = 0, RETIRED = 0.
//  Commit: at posedge with STAGE5IN=1, op in {ADD, SUB, AND, OR, ADDI, LW} and rd!=0:
//   - regs[rd] <= DATAIN.
//   - WB_EN <= 1, WB_RD <= rd, WB_DATA <= DATAIN.
//   - Otherwise WB_EN <= 0; WB_RD and WB_DATA hold their values.
//  Non-writing ops (SW, BEQ, JUMP, other): no register write, but they still retire.
//  Retire: at posedge with STAGE5IN=1:
//   - STAGE5OUT <= 1, WB_ADDR <= ADDRIN, RETIRED <= RETIRED+1 (wraps 2^CNTW-1 -> 0).
//   - STAGE5IN=0: STAGE5OUT <= 0; counter and WB_ADDR hold.
//  Latency: 1 cycle from STAGE5IN to register update and STAGE5OUT.
//  Register 0: reads 0 always; writes to rd=0 are discarded; busy[0] is never set.
//  Reads: RDATA_x = 0 if RADDR_x=0.
//   Else if a commit to RADDR_x is pending this cycle: DATAIN (bypass).
//   Else regs[RADDR_x].
//  Scoreboard, per register r, evaluated at posedge:
//   - set when ISSUE_EN=1 and ISSUE_RD=r (r!=0);
//   - cleared when a commit to r occurs;
//   - set and clear to the same r in one cycle: set wins (newer producer outstanding).
//  HAZARD_x = busy[RADDR_x] & ~(pending commit to RADDR_x this cycle); always 0 for index 0.
//  Simultaneous: ports A and B may read the same index and both receive identical data.
//  X on IRIN while STAGE5IN=0 must not affect any state.
// TESTING
//  1 RST pulse mid-run after writes -> all RDATA=0, RETIRED=0, STAGE5OUT=0, HAZARD=0 immediately (asynchronous, before the next edge).
//  2 STAGE5IN=1, ADD rd=3, DATAIN=16'h1234 -> next cycle WB_EN=1, WB_RD=3, regs[3]=16'h1234; RADDR_A=3 in the same cycle returns 16'h1234 via bypass.
//  3 ISSUE_EN rd=5, then LW rd=5 DATAIN=16'hBEEF two cycles later -> HAZARD_A=1 for RADDR_A=5 until commit cycle, 0 in commit cycle, busy clear after.
//  4 ISSUE_EN rd=7 in the same cycle as commit to rd=7 -> busy[7] stays 1, regs[7] updated.
//  5 SW and BEQ with STAGE5IN=1, then ADD rd=0 DATAIN=16'hFFFF -> no register changes, R0 reads 0, RETIRED += 3, STAGE5OUT pulses each.
//  6 Preload RETIRED to 16'hFFFF via 65535 retires (or force), one more -> RETIRED=0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Bundle of memory-stage inputs, register-file read ports, scoreboard and
// writeback status signals for the writeback stage.
interface writeback_stage_if #(
    parameter int DW   = 16,
    parameter int CNTW = 16
);
    logic            i_stage5in;
    logic [DW-1:0]   i_irin;
    logic [DW-1:0]   i_addrin;
    logic [DW-1:0]   i_datain;
    logic [3:0]      i_raddr_a;
    logic [3:0]      i_raddr_b;
    logic [DW-1:0]   o_rdata_a;
    logic [DW-1:0]   o_rdata_b;
    logic            i_issue_en;
    logic [3:0]      i_issue_rd;
    logic            o_hazard_a;
    logic            o_hazard_b;
    logic            o_wb_en;
    logic [3:0]      o_wb_rd;
    logic [DW-1:0]   o_wb_data;
    logic [DW-1:0]   o_wb_addr;
    logic            o_stage5out;
    logic [CNTW-1:0] o_retired;

    modport slave (
        input  i_stage5in, i_irin, i_addrin, i_datain, i_raddr_a, i_raddr_b,
               i_issue_en, i_issue_rd,
        output o_rdata_a, o_rdata_b, o_hazard_a, o_hazard_b, o_wb_en, o_wb_rd,
               o_wb_data, o_wb_addr, o_stage5out, o_retired
    );

    modport master (
        output i_stage5in, i_irin, i_addrin, i_datain, i_raddr_a, i_raddr_b,
               i_issue_en, i_issue_rd,
        input  o_rdata_a, o_rdata_b, o_hazard_a, o_hazard_b, o_wb_en, o_wb_rd,
               o_wb_data, o_wb_addr, o_stage5out, o_retired
    );
endinterface

// File: rtl/writeback_stage.sv
// Pipeline writeback stage: register file with bypassed combinational reads,
// per-register busy scoreboard for decode hazards, and a retired counter.
module writeback_stage #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic            r_wb_en;
    logic [3:0]      r_wb_rd;
    logic [DW-1:0]   r_wb_data;
    logic [DW-1:0]   r_wb_addr;
    logic            r_stage5out;
    logic [CNTW-1:0] r_retired;

    logic [3:0] w_op;
    logic [3:0] w_rd;
    logic       w_is_wr;
    logic       w_commit;
    logic       w_byp_a;
    logic       w_byp_b;
    wire        w_unused = &{1'b0, bus.i_irin[7:0]};

    assign w_op = bus.i_irin[15:12];
    assign w_rd = bus.i_irin[11:8];

    always_comb begin
        w_is_wr = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW: w_is_wr = 1'b1;
            default:                                       w_is_wr = 1'b0;
        endcase
    end

    // Gating on valid first keeps an undefined IR from reaching any state.
    assign w_commit = bus.i_stage5in && w_is_wr && (w_rd != 4'd0);
    assign w_byp_a  = w_commit && (w_rd == bus.i_raddr_a);
    assign w_byp_b  = w_commit && (w_rd == bus.i_raddr_b);

    assign bus.o_rdata_a  = (bus.i_raddr_a == 4'd0) ? '0 :
                            w_byp_a ? bus.i_datain : r_regs[bus.i_raddr_a];
    assign bus.o_rdata_b  = (bus.i_raddr_b == 4'd0) ? '0 :
                            w_byp_b ? bus.i_datain : r_regs[bus.i_raddr_b];
    assign bus.o_hazard_a = (bus.i_raddr_a != 4'd0) && r_busy[bus.i_raddr_a] && !w_byp_a;
    assign bus.o_hazard_b = (bus.i_raddr_b != 4'd0) && r_busy[bus.i_raddr_b] && !w_byp_b;

    // A new issue to r overrides a commit clearing r: the newer producer is still in flight.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign w_busy_next[gi] =
                    (bus.i_issue_en && (bus.i_issue_rd == 4'(gi))) ? 1'b1 :
                    (w_commit && (w_rd == 4'(gi)))                 ? 1'b0 :
                    r_busy[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_busy      <= '0;
            r_wb_en     <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_wb_addr   <= '0;
            r_stage5out <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_wb_en <= w_commit;
            if (w_commit) begin
                r_regs[w_rd] <= bus.i_datain;
                r_wb_rd      <= w_rd;
                r_wb_data    <= bus.i_datain;
            end
            r_stage5out <= bus.i_stage5in;
            if (bus.i_stage5in) begin
                r_wb_addr <= bus.i_addrin;
                r_retired <= r_retired + CNTW'(1);
            end
        end
    end

    assign bus.o_wb_en     = r_wb_en;
    assign bus.o_wb_rd     = r_wb_rd;
    assign bus.o_wb_data   = r_wb_data;
    assign bus.o_wb_addr   = r_wb_addr;
    assign bus.o_stage5out = r_stage5out;
    assign bus.o_retired   = r_retired;
endmodule
